// File: rtl/pcs_rx_pkg.sv
// ---------------------------------------------------------------------------
// pcs_rx_pkg
// Shared definitions for the 64b/66b PCS receive path.
//   SH_DATA / SH_CTRL : the two legal 66b sync header encodings
//   lockState_t       : block-lock FSM state encoding
//   isValidHdr()      : true for a legal sync header (01 or 10)
// ---------------------------------------------------------------------------
package pcs_rx_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP_WAIT = 2'd2
  } lockState_t;

  // 00 and 11 can never appear on a correctly aligned block
  function automatic logic isValidHdr(input logic [1:0] hdr);
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_block_lock.sv
// ---------------------------------------------------------------------------
// pcs_block_lock
// 64b/66b block-lock state machine with a one-cycle payload register stage.
// Watches sync headers from the gearbox, requests bit slips until a full
// window of clean headers is seen, then holds lock until too many bad headers
// land in one window.
//
// Parameters
//   LOCK_WINDOW   : valid blocks per header-test window
//   INVALID_LIMIT : bad headers per window that drop lock
//   SLIP_HOLDOFF  : valid blocks ignored after a slip (gearbox realigning)
// Ports
//   CLK        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   rx_hdr     in   2-bit sync header of the current block
//   rx_data    in   64-bit scrambled payload of the current block
//   rx_valid   in   rx_hdr/rx_data valid this cycle
//   D_out      out  registered payload (to the descrambler)
//   hdr_out    out  registered sync header aligned with D_out
//   out_valid  out  D_out/hdr_out valid
//   block_lock out  block alignment achieved
//   slip       out  one-cycle request to shift gearbox alignment by one bit
// ---------------------------------------------------------------------------
module pcs_block_lock
  import pcs_rx_pkg::*;
#(
  parameter int LOCK_WINDOW   = 64,
  parameter int INVALID_LIMIT = 16,
  parameter int SLIP_HOLDOFF  = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [1:0]  rx_hdr,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  output logic [63:0] D_out,
  output logic [1:0]  hdr_out,
  output logic        out_valid,
  output logic        block_lock,
  output logic        slip
);

  localparam int CW = $clog2(LOCK_WINDOW + 1);
  localparam int IW = $clog2(INVALID_LIMIT + 1);
  localparam int HW = (SLIP_HOLDOFF < 1) ? 1 : $clog2(SLIP_HOLDOFF + 1);

  localparam logic [CW-1:0] LW_C = CW'(LOCK_WINDOW);
  localparam logic [IW-1:0] IL_C = IW'(INVALID_LIMIT);
  localparam logic [HW-1:0] HO_C = HW'(SLIP_HOLDOFF);

  lockState_t    r_state;
  logic [CW-1:0] r_shCnt;
  logic [IW-1:0] r_shInvalidCnt;
  logic [HW-1:0] r_holdCnt;

  logic          w_hdrBad;
  logic [CW-1:0] w_cntInc;
  logic [IW-1:0] w_invInc;
  logic [HW-1:0] w_holdInc;

  // Counter values as they would be after accepting the current block.
  // RESET_CNT behaves as TEST_SH starting from cleared counters, so a block
  // arriving straight after reset is tested rather than lost. Counters are
  // cleared whenever they hit their limit, so the increments never wrap.
  always_comb begin
    w_hdrBad  = !isValidHdr(rx_hdr);
    w_cntInc  = '0;
    w_invInc  = '0;
    if (r_state == RESET_CNT) begin
      w_cntInc = CW'(1);
      w_invInc = IW'(w_hdrBad);
    end else begin
      w_cntInc = r_shCnt + CW'(1);
      w_invInc = r_shInvalidCnt + IW'(w_hdrBad);
    end
    w_holdInc = r_holdCnt + HW'(1);
  end

  // Output register stage plus the lock FSM. The payload path registers
  // unconditionally so latency is independent of lock state. Slip defaults
  // low every cycle; it is only raised on the edge that leaves TEST_SH for
  // SLIP_WAIT, and SLIP_WAIT always consumes at least one valid block, so two
  // slips can never be back to back. Idle cycles freeze all FSM state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      D_out          <= '0;
      hdr_out        <= '0;
      out_valid      <= 1'b0;
      block_lock     <= 1'b0;
      slip           <= 1'b0;
      r_shCnt        <= '0;
      r_shInvalidCnt <= '0;
      r_holdCnt      <= '0;
      r_state        <= RESET_CNT;
    end else begin
      D_out     <= rx_data;
      hdr_out   <= rx_hdr;
      out_valid <= rx_valid;
      slip      <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          RESET_CNT, TEST_SH: begin
            r_state <= TEST_SH;
            if (!block_lock) begin
              if (w_hdrBad) begin
                slip           <= 1'b1;
                r_shCnt        <= '0;
                r_shInvalidCnt <= '0;
                r_holdCnt      <= '0;
                r_state        <= SLIP_WAIT;
              end else if (w_cntInc == LW_C) begin
                block_lock     <= 1'b1;
                r_shCnt        <= '0;
                r_shInvalidCnt <= '0;
              end else begin
                r_shCnt        <= w_cntInc;
                r_shInvalidCnt <= '0;
              end
            end else begin
              // Loss of lock is checked first so it wins on the last block
              if (w_invInc == IL_C) begin
                block_lock     <= 1'b0;
                slip           <= 1'b1;
                r_shCnt        <= '0;
                r_shInvalidCnt <= '0;
                r_holdCnt      <= '0;
                r_state        <= SLIP_WAIT;
              end else if (w_cntInc == LW_C) begin
                r_shCnt        <= '0;
                r_shInvalidCnt <= '0;
              end else begin
                r_shCnt        <= w_cntInc;
                r_shInvalidCnt <= w_invInc;
              end
            end
          end
          SLIP_WAIT: begin
            if (w_holdInc >= HO_C) begin
              r_holdCnt      <= '0;
              r_shCnt        <= '0;
              r_shInvalidCnt <= '0;
              r_state        <= TEST_SH;
            end else begin
              r_holdCnt <= w_holdInc;
            end
          end
          default: r_state <= RESET_CNT;
        endcase
      end
    end
  end

endmodule

// File: doc/pcs_block_lock.md
PCS_BLOCK_LOCK -- requirements
Module: pcs_block_lock

Interface
REQ-001 SHALL have parameter LOCK_WINDOW, default 64: number of valid blocks per header-test window.
REQ-002 SHALL have parameter INVALID_LIMIT, default 16: invalid headers per window that drop lock.
REQ-003 SHALL have parameter SLIP_HOLDOFF, default 2: valid blocks ignored after a slip while the gearbox realigns.
REQ-004 SHALL have port CLK  input  1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port rx_hdr  input  2: 66b sync header of the current block from the gearbox.
REQ-007 SHALL have port rx_data  input  64: scrambled payload of the current block.
REQ-008 SHALL have port rx_valid  input  1: rx_hdr/rx_data valid this cycle.
REQ-009 SHALL have port D_out  output  64: registered payload, feeds Sr_In of Descrambler_64bit.
REQ-010 SHALL have port hdr_out  output  2: registered sync header aligned with D_out.
REQ-011 SHALL have port out_valid  output  1: D_out/hdr_out valid.
REQ-012 SHALL have port block_lock  output  1: block alignment achieved.
REQ-013 SHALL have port slip  output  1: one-cycle request to gearbox to shift alignment by one bit.

Function
REQ-014 SHALL treat rx_hdr 2'b01 (data) and 2'b10 (control) as valid headers; 2'b00 and 2'b11 as invalid.
REQ-015 SHALL register rx_data, rx_hdr, rx_valid to D_out, hdr_out, out_valid with exactly 1-cycle latency, independent of lock state.
REQ-016 SHALL implement FSM states RESET_CNT, TEST_SH, SLIP_WAIT; RESET_CNT clears sh_cnt and sh_invalid_cnt and enters TEST_SH in the same cycle.
REQ-017 SHALL in TEST_SH, per valid block: sh_cnt += 1; sh_invalid_cnt += 1 if header invalid.
REQ-018 SHALL, when unlocked, on any invalid header: pulse slip next cycle, clear counters, enter SLIP_WAIT.
REQ-019 SHALL, when unlocked and sh_cnt reaches LOCK_WINDOW with sh_invalid_cnt 0, assert block_lock the cycle after the final block and clear counters.
REQ-020 SHALL, when locked and sh_invalid_cnt reaches INVALID_LIMIT, deassert block_lock and pulse slip the cycle after that block, clear counters, enter SLIP_WAIT.
REQ-021 SHALL, when locked and sh_cnt reaches LOCK_WINDOW with sh_invalid_cnt < INVALID_LIMIT, clear counters and remain locked.
REQ-022 SHALL, if the LOCK_WINDOW-th block is also the INVALID_LIMIT-th invalid, give loss of lock priority.
REQ-023 SHALL in SLIP_WAIT count SLIP_HOLDOFF valid blocks ignoring headers, then return to TEST_SH with counters 0.
REQ-024 SHALL hold all counters and FSM state in any cycle with rx_valid = 0.
REQ-025 SHALL size sh_cnt at $clog2(LOCK_WINDOW+1) bits and sh_invalid_cnt at $clog2(INVALID_LIMIT+1) bits; neither wraps.
REQ-026 SHALL never assert slip in two consecutive cycles.

Reset
REQ-027 SHALL on rst: D_out = 0, hdr_out = 0, out_valid = 0, block_lock = 0, slip = 0, counters = 0, FSM = RESET_CNT, effective next edge.
REQ-028 SHALL let rst override all other events, including mid-window and during SLIP_WAIT.

Structure
REQ-029 SHALL place SH_DATA = 2'b01, SH_CTRL = 2'b10 and the FSM state typedef in shared package pcs_rx_pkg.
REQ-030 SHALL be a single module with no sub-modules; FSM, counters and output register inline.

Verification
REQ-031 SHALL cover: reset, then 64 blocks hdr=01 -> block_lock=1 one cycle after 64th, slip never asserted.
REQ-032 SHALL cover: unlocked, 10th block hdr=00 -> slip=1 for one cycle; next 2 blocks ignored; lock after 64 further good blocks.
REQ-033 SHALL cover: locked, 15 hdr=11 in one 64-block window -> lock held; 16 in next window -> block_lock=0 and slip=1 one cycle after 16th.
REQ-034 SHALL cover: rx_valid toggling every cycle with hdr=10 -> lock after 64 valid blocks (128 cycles), counters frozen on idle cycles.
REQ-035 SHALL cover: rst high for one cycle while locked at sh_cnt=30 -> block_lock=0, out_valid=0, slip=0 next edge; relock needs full 64 blocks.
REQ-036 SHALL cover: rx_data=64'hDEADBEEF01234567, rx_hdr=10 -> D_out/hdr_out match one cycle later with out_valid=1.
